// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - Slice-serial accumulator: A <= A + B through one external SLICE-bit adder.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic [WIDTH-1:0] Din,
    input  logic [SLICE-1:0] adder_sum,
    input  logic             adder_cout,
    output logic [SLICE-1:0] adder_a,
    output logic [SLICE-1:0] adder_b,
    output logic             adder_cin,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             last_slice;

    assign k_d        = k_q + 1'b1;
    assign last_slice = (k_q == KW'(NSLICE - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LoadB) begin
                        b_q <= Din;
                    end
                    // ClearA wins over Run so a clear never launches an add.
                    if (ClearA) begin
                        a_q    <= '0;
                        cout_q <= 1'b0;
                    end else if (Run) begin
                        state_q <= ADD;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ADD: begin
                    a_q[int'(k_q)*SLICE +: SLICE] <= adder_sum;
                    carry_q                       <= adder_cout;
                    if (last_slice) begin
                        cout_q  <= adder_cout;
                        k_q     <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_d;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // The slice adder is combinational, so its operands come straight from the registers.
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (state_q == ADD) begin
            adder_a   = a_q[int'(k_q)*SLICE +: SLICE];
            adder_b   = b_q[int'(k_q)*SLICE +: SLICE];
            adder_cin = (k_q == '0) ? 1'b0 : carry_q;
        end
    end

    assign A_out = a_q;
    assign B_out = b_q;
    assign Cout  = cout_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - Directed bench with result scoreboard for nibble_serial_add_ctrl.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Run;
    logic             LoadB;
    logic             ClearA;
    logic [WIDTH-1:0] Din;
    logic [SLICE-1:0] adder_sum;
    logic             adder_cout;
    logic [SLICE-1:0] adder_a;
    logic [SLICE-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             Cout;
    logic             Busy;
    logic             Done;

    int tests = 0;
    int fails = 0;

    logic [WIDTH:0]   sb_q[$];
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .LoadB      (LoadB),
        .ClearA     (ClearA),
        .Din        (Din),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .A_out      (A_out),
        .B_out      (B_out),
        .Cout       (Cout),
        .Busy       (Busy),
        .Done       (Done)
    );

    // External ripple-carry slice adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_a();
        ClearA = 1'b1;
        step();
        ClearA = 1'b0;
        m_a = '0;
    endtask

    task automatic run_add(input string tag, input bit load, input logic [WIDTH-1:0] din,
                           input bit disturb);
        logic [WIDTH:0]   exp;
        logic [NSLICE-1:0] cin_exp;
        logic [NSLICE-1:0] cin_obs;
        logic             carry;
        logic [SLICE:0]   t;
        int               busy_n;
        int               guard;
        if (load) begin
            LoadB = 1'b1;
            Din   = din;
            m_b   = din;
        end
        exp = {1'b0, m_a} + {1'b0, m_b};
        sb_q.push_back(exp);
        carry = 1'b0;
        for (int i = 0; i < NSLICE; i++) begin
            cin_exp[i] = carry;
            t = {1'b0, m_a[i*SLICE +: SLICE]} + {1'b0, m_b[i*SLICE +: SLICE]} + {4'b0, carry};
            carry = t[SLICE];
        end
        Run = 1'b1;
        step();
        LoadB   = 1'b0;
        busy_n  = 0;
        cin_obs = '0;
        guard   = 0;
        while (!Done && guard < 12) begin
            if (Busy) begin
                if (busy_n < NSLICE) cin_obs[busy_n] = adder_cin;
                busy_n++;
            end
            if (disturb && busy_n == 1) begin
                LoadB  = 1'b1;
                ClearA = 1'b1;
                Din    = 16'hAAAA;
            end else begin
                LoadB  = 1'b0;
                ClearA = 1'b0;
            end
            step();
            guard++;
        end
        LoadB  = 1'b0;
        ClearA = 1'b0;
        check({tag, " done"}, 32'(Done), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(NSLICE));
        check({tag, " cin_seq"}, 32'(cin_obs), 32'(cin_exp));
        exp = sb_q.pop_front();
        check({tag, " A_out"}, 32'(A_out), 32'(exp[WIDTH-1:0]));
        check({tag, " Cout"}, 32'(Cout), 32'(exp[WIDTH]));
        check({tag, " B_out"}, 32'(B_out), 32'(m_b));
        m_a = exp[WIDTH-1:0];
        Run = 1'b0;
        step();
        check({tag, " back_idle"}, 32'({Busy, Done}), 32'd0);
    endtask

    initial begin
        logic [WIDTH:0] exp;
        int             nb;
        Reset  = 1'b1;
        Run    = 1'b0;
        LoadB  = 1'b0;
        ClearA = 1'b0;
        Din    = '0;
        m_a    = '0;
        m_b    = '0;
        #1;
        check("reset regs", 32'({A_out, B_out}), 32'd0);
        check("reset flags", 32'({Cout, Busy, Done}), 32'd0);
        check("reset adder_ports", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        #11;
        Reset = 1'b0;
        step();

        // 1: first add
        LoadB = 1'b1; Din = 16'h0001; m_b = 16'h0001;
        step();
        LoadB = 1'b0;
        check("t1 loadb", 32'(B_out), 32'h0001);
        run_add("t1", 1'b0, '0, 1'b0);

        // 2: full carry ripple
        run_add("t2a", 1'b1, 16'hFFFE, 1'b0);
        run_add("t2b", 1'b1, 16'h0001, 1'b0);

        // 3: mixed carries, LoadB together with Run
        clear_a();
        run_add("t3a", 1'b1, 16'h1234, 1'b0);
        run_add("t3b", 1'b1, 16'h0FCD, 1'b0);

        // 4: Run held high gives exactly one add
        exp = {1'b0, m_a} + {1'b0, m_b};
        sb_q.push_back(exp);
        Run = 1'b1;
        nb  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Busy) nb++;
        end
        check("t4 busy_cycles", 32'(nb), 32'(NSLICE));
        check("t4 done_held", 32'(Done), 32'd1);
        exp = sb_q.pop_front();
        check("t4 A_out", 32'(A_out), 32'(exp[WIDTH-1:0]));
        m_a = exp[WIDTH-1:0];
        Run = 1'b0;
        step();
        check("t4 idle", 32'({Busy, Done}), 32'd0);
        run_add("t4 second", 1'b0, '0, 1'b0);

        // 5: async reset mid-add
        Run = 1'b1;
        step();
        step();
        step();
        #2;
        Reset = 1'b1;
        #1;
        check("t5 A_out", 32'(A_out), 32'd0);
        check("t5 flags", 32'({Busy, Done}), 32'd0);
        Run = 1'b0;
        #2;
        Reset = 1'b0;
        m_a = '0;
        m_b = '0;
        step();
        run_add("t5 recover", 1'b1, 16'h0005, 1'b0);

        // 6: LoadB/ClearA ignored in ADD, ClearA beats Run in IDLE
        run_add("t6 disturb", 1'b1, 16'h0003, 1'b1);
        run_add("t6 carry", 1'b1, 16'hFFFF, 1'b0);
        Run = 1'b1; ClearA = 1'b1;
        step();
        Run = 1'b0; ClearA = 1'b0;
        check("t6 clear A", 32'(A_out), 32'd0);
        check("t6 clear Cout", 32'(Cout), 32'd0);
        check("t6 no_add", 32'(Busy), 32'd0);
        step();
        check("t6 still_idle", 32'({Busy, Done}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
